// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
// Optional port: conflict_cnt, present only when SHARED_REG_ARB_CONFLICT_CNT_EN is defined.
interface shared_reg_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [OW-1:0]  owner;
  logic           busy;

`ifdef SHARED_REG_ARB_CONFLICT_CNT_EN
  logic [CW-1:0]  conflict_cnt;

  modport master (output req, wdata, input gnt, ack, q, owner, busy, conflict_cnt);
  modport slave  (input req, wdata, output gnt, ack, q, owner, busy, conflict_cnt);
`else
  modport master (output req, wdata, input gnt, ack, q, owner, busy);
  modport slave  (input req, wdata, output gnt, ack, q, owner, busy);
`endif

  // Reject parameter combinations the arbiter is not built for
  if (N < 2 || N > 16 || W < 1 || CW < 1) begin : g_param_check
    $error("shared_reg_arbiter_if: unsupported N/W/CW");
  end

endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin grant/commit arbiter for one register shared by N writers.
// Optional feature: SHARED_REG_ARB_CONFLICT_CNT_EN adds a saturating count
// of arbitrations that saw two or more effective requests.
module shared_reg_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter int unsigned CW        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);

  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [N-1:0]  r_ack, w_ack_nxt;
  logic [W-1:0]  r_q, w_q_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_ptr, w_ptr_nxt;
  logic          r_busy, w_busy_nxt;

  logic [N-1:0]  w_eff;
  logic          w_found;
  logic [OW-1:0] w_winner;
  logic          w_contended;

  // Reject parameter combinations the arbiter is not built for
  if (N < 2 || N > 16 || W < 1 || CW < 1) begin : g_param_check
    $error("shared_reg_arbiter: unsupported N/W/CW");
  end

  // Rotating priority search from ptr; the requester being acked is masked
  always_comb begin
    int unsigned v_idx;
    w_eff       = bus.req & ~r_ack;
    w_found     = 1'b0;
    w_winner    = '0;
    v_idx       = 0;
    w_contended = ($countones(w_eff) >= 2);
    for (int unsigned i = 0; i < N; i++) begin
      v_idx = 32'(r_ptr) + i;
      if (v_idx >= N) v_idx = v_idx - N;
      if (!w_found && w_eff[OW'(v_idx)]) begin
        w_found  = 1'b1;
        w_winner = OW'(v_idx);
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = '0;
    w_q_nxt     = r_q;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = N'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        // Commit if the owner still requests, otherwise abort; either way rotate
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;
        w_state_nxt = S_IDLE;
        if (bus.req[r_owner]) begin
          w_q_nxt   = bus.wdata[32'(r_owner) * W +: W];
          w_ack_nxt = N'(1) << r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_q     <= RESET_VAL;
      r_owner <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_q     <= w_q_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.ack   = r_ack;
  assign bus.q     = r_q;
  assign bus.owner = r_owner;
  assign bus.busy  = r_busy;

`ifdef SHARED_REG_ARB_CONFLICT_CNT_EN
  logic [CW-1:0] r_conflict_cnt;

  // Count contended IDLE-to-GRANT transitions, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (r_state == S_IDLE && w_found && w_contended && r_conflict_cnt != '1) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter for a single shared register written by N independent requesters. It replaces multi-driver assignment to a shared variable, whose result depends on evaluation order, with an explicit grant/commit handshake. Exactly one writer commits per arbitration, so the final value is always deterministic. It sits between requester blocks and any shared configuration or status register that more than one block must update.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data width of the shared register
- RESET_VAL, 0, value of q after reset
- CW, 16, width of the conflict counter (used only with the macro)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req  in  N  per-requester write request; held high until matching ack
- wdata  in  N*W  flattened write data; requester i occupies bits [i*W +: W]
- gnt  out  N  one-hot grant, registered
- ack  out  N  one-hot single-cycle commit pulse, registered
- q  out  W  shared register value
- owner  out  clog2(N) (min 1)  index of the last granted requester
- busy  out  1  high while state is GRANT
- conflict_cnt  out  CW  contended-arbitration count (port present only with the macro)

## Operation
- One clock domain. Reset is synchronous and active-high.
- Reset values: gnt=0, ack=0, q=RESET_VAL, owner=0, busy=0, ptr=0, conflict_cnt=0, state=IDLE.
- ptr is the internal round-robin pointer. The search for a winner starts at index ptr and wraps modulo N.
- Effective requests: eff = req & ~ack. The requester currently being acked is masked for that cycle. This prevents a re-grant while its req is still falling.
- IDLE state:
  - If eff is nonzero: winner = first set bit of eff at or after ptr, with wrap. Then gnt<=onehot(winner), owner<=winner, busy<=1, state<=GRANT.
  - If eff is zero: stay in IDLE.
- GRANT, req[owner]=1 (commit):
  - q<=wdata[owner]; ack[owner]<=1; gnt<=0; busy<=0.
  - ptr<=(owner+1) mod N; state<=IDLE.
- GRANT, req[owner]=0 (abort):
  - gnt<=0; busy<=0; no ack; q unchanged.
  - ptr<=(owner+1) mod N; state<=IDLE.
- ack is high for exactly one cycle per commit. It is never asserted without a preceding grant cycle.
- wdata is sampled only at the commit edge, and only from the owner. Other requesters' wdata is ignored.
- Requests arriving while in GRANT wait. Nothing is dropped: req is level-held by the requester.
- Requester contract: hold req and wdata stable from assertion until ack is seen, then drop req on the next edge.
- rst in any state returns everything to reset values at that edge. An in-flight grant is discarded, with no ack and no q update.

## Timing
- Request to grant: req high before edge k gives gnt high after edge k.
- Grant to commit: q updates and ack rises after edge k+1.
- Sustained throughput: one commit per 2 cycles.
- Back-to-back commits to different requesters: ack pulses land on every other cycle.
- Fairness: a requester waits at most N−1 other commits after its req is seen.
- gnt and ack are never high in the same cycle.
- busy is identical to |gnt.

## Configuration
- SHARED_REG_ARB_CONFLICT_CNT_EN defined:
  - conflict_cnt port exists.
  - It increments by 1 at each IDLE-to-GRANT transition where popcount(eff) ≥ 2.
  - It saturates at all-ones and clears only on rst.
- Not defined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles with req=4'b1111 → gnt=0, ack=0, q=RESET_VAL, busy=0 throughout. First grant goes to requester 0 on the first edge after rst drops.
- Single writer: req[2]=1, wdata[2]=8'hA5 → gnt=4'b0100 one cycle later. Next cycle: ack=4'b0100, q=8'hA5. No second grant while req[2] is falling.
- Simultaneous: req=4'b1011 with data 11/22/44 on requesters 0/1/3, each dropped on ack → acks in order 0,1,3 on cycles 2,4,6. Final q=44.
- Fairness: req0 and req1 held permanently → grants alternate 0,1,0,1. No requester is granted twice in a row.
- Abort and reset:
  - Drop req[1] during its GRANT cycle → no ack, q unchanged, ptr advances to 2.
  - Separately, assert rst during GRANT → no ack, all reset values next cycle.
- Macro on, CW=2: five contended arbitrations (req=4'b0011 repeatedly) → conflict_cnt goes 1,2,3,3,3.
- Macro off: the port is absent, and the same stimulus gives identical q and ack sequences.
